// File: rtl/addsub_pipe.sv
// ---------------------------------------------------------------------------
// addsub_pipe
// Pipelined two's-complement mantissa adder/subtractor with a valid/ready
// handshake, a sideband tag, and sign/zero/magnitude flags for the
// normaliser that follows.
//
// Stage 0 registers the arithmetic result computed from the accepted inputs.
// Stages 1..LATENCY-1 carry that result to the output. A single global
// advance enable moves every stage together. Bubbles move like data.
//
// Optional build macro: ADDSUB_LZC_EN
//   When defined, this macro adds the out_lzc port. out_lzc is the
//   leading-zero count of out_mag, and it equals WIDTH when out_mag is 0.
//   The count is registered in stage 1 when LATENCY >= 2, and in stage 0
//   when LATENCY == 1. The latency does not change.
// ---------------------------------------------------------------------------
module addsub_pipe #(
  parameter int WIDTH   = 24,  // 2..64
  parameter int LATENCY = 2,   // 1..4
  parameter int TAG_W   = 8    // 1..32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_neg,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
`ifdef ADDSUB_LZC_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_lzc
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] mag;
    logic             neg;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } res_t;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  res_t               res_in;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     full;
  logic               adv;
  logic [LATENCY-1:0] vld;
  res_t               stg [LATENCY];

  // Every stage advances together.
  // A stage stalls only when a result is presented and nobody takes it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;

  // Arithmetic: add or subtract, then derive magnitude, sign and zero.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block, so no
    // path through the block can leave a value unassigned (which would
    // infer a latch).
    res_in = '0;
    b_eff  = in_op ? ~in_b : in_b;
    full   = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, in_op};

    res_in.sum  = full[WIDTH-1:0];
    res_in.cout = full[WIDTH];
    res_in.neg  = in_op && !full[WIDTH];
    res_in.mag  = res_in.neg ? (~full[WIDTH-1:0] + ONE_W) : full[WIDTH-1:0];
    // An add that wraps to zero with a carry out is 2^WIDTH, not zero.
    res_in.zero = (full[WIDTH-1:0] == '0) && (in_op || !full[WIDTH]);
    res_in.tag  = in_tag;
  end

  // Pipeline stages: load stage 0 and shift the rest when the pipe advances.
  always_ff @(posedge clk) begin
    // NOTE: the data registers are cleared on reset together with the valid
    // bits. This keeps the outputs at 0 after reset, and it is not needed
    // for correct operation.
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
    end else if (adv) begin
      // NOTE: state registers use non-blocking assignments, so every stage
      // reads the value its predecessor held before this edge.
      vld[0] <= in_valid;
      stg[0] <= res_in;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        stg[i] <= stg[i-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_sum   = stg[LATENCY-1].sum;
  assign out_cout  = stg[LATENCY-1].cout;
  assign out_mag   = stg[LATENCY-1].mag;
  assign out_neg   = stg[LATENCY-1].neg;
  assign out_zero  = stg[LATENCY-1].zero;
  assign out_tag   = stg[LATENCY-1].tag;

`ifdef ADDSUB_LZC_EN
  localparam int LZW = $clog2(WIDTH+1);

  // Count leading zeros, scanning down from the MSB. Returns WIDTH for 0.
  function automatic logic [LZW-1:0] lzc_f(input logic [WIDTH-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n     = n + LZW'(1);
      end
    end
    return n;
  endfunction

  if (LATENCY == 1) begin : g_lzc_s0
    logic [LZW-1:0] lzc_q;

    // With one stage, the count is taken straight from the new magnitude.
    always_ff @(posedge clk) begin
      if (rst)      lzc_q <= '0;
      else if (adv) lzc_q <= lzc_f(res_in.mag);
    end

    assign out_lzc = lzc_q;
  end else begin : g_lzc_s1
    logic [LZW-1:0] lzc_q [1:LATENCY-1];

    // The count is taken from the registered stage-0 magnitude, then carried
    // along with the result.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 1; i < LATENCY; i++) lzc_q[i] <= '0;
      end else if (adv) begin
        lzc_q[1] <= lzc_f(stg[0].mag);
        for (int i = 2; i < LATENCY; i++) lzc_q[i] <= lzc_q[i-1];
      end
    end

    assign out_lzc = lzc_q[LATENCY-1];
  end
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_addsub_pipe
// Directed bench for addsub_pipe (WIDTH=24, LATENCY=2, TAG_W=8).
// The bench has a table of hand-computed vectors, applied one at a time.
// Three hand-written sequences then cover:
//   - a back-to-back stream with a downstream stall,
//   - a reset while two ops are in flight,
//   - recovery after that reset.
// Out_lzc checks are enabled when ADDSUB_LZC_EN is defined.
// ---------------------------------------------------------------------------
module tb_addsub_pipe;

  localparam int W = 24;
  localparam int L = 2;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_op;
  logic [T-1:0] in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic [W-1:0] out_mag;
  logic         out_neg;
  logic         out_zero;
  logic [T-1:0] out_tag;
`ifdef ADDSUB_LZC_EN
  logic [4:0]   out_lzc;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [T-1:0] tag;
    logic [W-1:0] sum;
    logic         cout;
    logic [W-1:0] mag;
    logic         neg;
    logic         zero;
    logic [4:0]   lzc;
  } vec_t;

  vec_t vecs [10];
  vec_t strm [6];
  vec_t exp_q [$];

  addsub_pipe #(.WIDTH(W), .LATENCY(L), .TAG_W(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_mag   (out_mag),
    .out_neg   (out_neg),
    .out_zero  (out_zero),
`ifdef ADDSUB_LZC_EN
    .out_lzc   (out_lzc),
`endif
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                              input logic [T-1:0] tag, input logic [W-1:0] sum, input logic cout,
                              input logic [W-1:0] mag, input logic neg, input logic zero,
                              input logic [4:0] lzc);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.tag = tag;
    v.sum = sum; v.cout = cout; v.mag = mag; v.neg = neg; v.zero = zero; v.lzc = lzc;
    return v;
  endfunction

  // Integer reference model: it works on signed values, not on the
  // inverted-operand adder.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    longint d;
    longint m;
    r = v;
    if (!v.op) d = longint'(v.a) + longint'(v.b);
    else       d = longint'(v.a) - longint'(v.b);
    m      = (d < 0) ? -d : d;
    r.sum  = d[W-1:0];
    r.cout = v.op ? (v.a >= v.b) : d[W];
    r.neg  = v.op && (v.a < v.b);
    r.mag  = v.op ? m[W-1:0] : d[W-1:0];
    r.zero = (d == 0);
    return r;
  endfunction

  task automatic drive(input vec_t v);
    in_a   = v.a;
    in_b   = v.b;
    in_op  = v.op;
    in_tag = v.tag;
  endtask

  // Apply a single op with out_ready high, then check the 2-cycle latency
  // and every output field.
  task automatic run_vec(input string nm, input vec_t v);
    drive(v);
    in_valid = 1'b1;
    check({nm, ".in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    check({nm, ".early_valid"}, out_valid, 0);
    tick();
    check({nm, ".valid"}, out_valid, 1);
    check({nm, ".sum"},   out_sum,   v.sum);
    check({nm, ".cout"},  out_cout,  v.cout);
    check({nm, ".mag"},   out_mag,   v.mag);
    check({nm, ".neg"},   out_neg,   v.neg);
    check({nm, ".zero"},  out_zero,  v.zero);
    check({nm, ".tag"},   out_tag,   v.tag);
`ifdef ADDSUB_LZC_EN
    check({nm, ".lzc"},   out_lzc,   v.lzc);
`endif
    tick();
    check({nm, ".drain"}, out_valid, 0);
  endtask

  initial begin
    vec_t e;
    int   sent;
    int   got;
    logic stalled;
    logic [W-1:0] sv_sum;
    logic [T-1:0] sv_tag;
    logic         sv_valid;

    //             a          b          op    tag    sum        cout  mag        neg   zero  lzc
    vecs[0] = mk(24'hFFFFFF, 24'h000001, 1'b0, 8'h5A, 24'h000000, 1'b1, 24'h000000, 1'b0, 1'b0, 5'd24);
    vecs[1] = mk(24'h000005, 24'h000009, 1'b1, 8'h11, 24'hFFFFFC, 1'b0, 24'h000004, 1'b1, 1'b0, 5'd21);
    vecs[2] = mk(24'h123456, 24'h123456, 1'b1, 8'h22, 24'h000000, 1'b1, 24'h000000, 1'b0, 1'b1, 5'd24);
    vecs[3] = mk(24'hFFFFFF, 24'hFFFFFF, 1'b0, 8'h33, 24'hFFFFFE, 1'b1, 24'hFFFFFE, 1'b0, 1'b0, 5'd0);
    vecs[4] = mk(24'h000000, 24'hFFFFFF, 1'b1, 8'h44, 24'h000001, 1'b0, 24'hFFFFFF, 1'b1, 1'b0, 5'd0);
    vecs[5] = mk(24'h000000, 24'h000000, 1'b1, 8'h55, 24'h000000, 1'b1, 24'h000000, 1'b0, 1'b1, 5'd24);
    vecs[6] = mk(24'h000000, 24'h000000, 1'b0, 8'h66, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b1, 5'd24);
    vecs[7] = mk(24'h800000, 24'h7FFFFF, 1'b1, 8'h77, 24'h000001, 1'b1, 24'h000001, 1'b0, 1'b0, 5'd23);
    vecs[8] = mk(24'h000010, 24'h000020, 1'b0, 8'h88, 24'h000030, 1'b0, 24'h000030, 1'b0, 1'b0, 5'd18);
    vecs[9] = mk(24'h7FFFFF, 24'h800000, 1'b1, 8'h99, 24'hFFFFFF, 1'b0, 24'h000001, 1'b1, 1'b0, 5'd23);

    strm[0] = mk(24'h000100, 24'h000023, 1'b0, 8'hA0, '0, 0, '0, 0, 0, '0);
    strm[1] = mk(24'h000050, 24'h000060, 1'b1, 8'hA1, '0, 0, '0, 0, 0, '0);
    strm[2] = mk(24'hABCDEF, 24'h012345, 1'b1, 8'hA2, '0, 0, '0, 0, 0, '0);
    strm[3] = mk(24'hF00000, 24'h200000, 1'b0, 8'hA3, '0, 0, '0, 0, 0, '0);
    strm[4] = mk(24'h000777, 24'h000777, 1'b1, 8'hA4, '0, 0, '0, 0, 0, '0);
    strm[5] = mk(24'h000001, 24'h000002, 1'b0, 8'hA5, '0, 0, '0, 0, 0, '0);

    // Reset with junk on the inputs: in_ready is low, and the outputs are 0
    // after reset.
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(vecs[3]);
    #1;
    check("rst.in_ready", in_ready, 0);
    tick();
    tick();
    check("rst.valid", out_valid, 0);
    check("rst.sum",   out_sum,   0);
    check("rst.tag",   out_tag,   0);
    check("rst.zero",  out_zero,  0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Stream of 6 ops; out_ready is low in cycles 3..5.
    sent    = 0;
    got     = 0;
    stalled = 1'b0;
    sv_sum  = '0;
    sv_tag  = '0;
    sv_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 6) begin
        drive(strm[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        check("stall.valid_stable", out_valid, sv_valid);
        check("stall.sum_stable",   out_sum,   sv_sum);
        check("stall.tag_stable",   out_tag,   sv_tag);
      end
      check($sformatf("stream.in_ready%0d", cyc), in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream.extra_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("stream%0d.sum", got), out_sum,  e.sum);
          check($sformatf("stream%0d.mag", got), out_mag,  e.mag);
          check($sformatf("stream%0d.neg", got), out_neg,  e.neg);
          check($sformatf("stream%0d.zero", got), out_zero, e.zero);
          check($sformatf("stream%0d.tag", got), out_tag,  e.tag);
        end
        got++;
      end
      stalled  = out_valid && !out_ready;
      sv_sum   = out_sum;
      sv_tag   = out_tag;
      sv_valid = out_valid;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(strm[sent]));
        sent++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream.count", got, 6);
    check("stream.leftover", exp_q.size(), 0);
    #1;
    check("stream.no_dup", out_valid, 0);

    // Put two ops in flight while the output is held, then reset.
    out_ready = 1'b0;
    drive(vecs[3]);
    in_valid = 1'b1;
    tick();
    drive(vecs[4]);
    check("flight.accept2", in_ready, 1);
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("flight.rst_in_ready", in_ready, 0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    check("flight.valid", out_valid, 0);
    check("flight.sum",   out_sum,   0);
    check("flight.cout",  out_cout,  0);
    check("flight.tag",   out_tag,   0);
    tick();
    check("flight.no_leak", out_valid, 0);
    run_vec("post_rst", vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
